// File: rtl/insn_loader.sv
// Framed host-byte to 32-bit instruction word loader feeding the MC instruction FIFO.
// Optional trailing XOR checksum byte enabled by defining INSN_LOADER_CHECKSUM_EN.
module insn_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [31:0]      fifo_din,
  output logic             prog_en,
  output logic             frame_done,
  output logic             err_csum,
  output logic [LEN_W-1:0] word_count
);

`ifdef INSN_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, LEN, DATA} state_t;
`endif

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n;
  logic [LEN_W-1:0] word_count_n, wc_inc;
  logic [1:0]       byte_idx, byte_idx_n;
  logic [31:0]      word_buf, word_buf_n;
  logic [31:0]      fifo_din_n;
  logic             pending, pending_n;
  logic             fifo_wr_n, frame_done_n, prog_en_n;
  logic             accept, emit;
`ifdef INSN_LOADER_CHECKSUM_EN
  logic [7:0]       acc, acc_n;
  logic             err_n;
`endif

  // s_ready is a pure function of state so it never loops back through s_valid
  assign s_ready = !pending;
  assign accept  = s_valid && !pending;
  assign wc_inc  = word_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      word_count <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      fifo_din   <= '0;
      pending    <= 1'b0;
      fifo_wr    <= 1'b0;
      frame_done <= 1'b0;
      prog_en    <= 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
      acc        <= '0;
      err_csum   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      len        <= len_n;
      word_count <= word_count_n;
      byte_idx   <= byte_idx_n;
      word_buf   <= word_buf_n;
      fifo_din   <= fifo_din_n;
      pending    <= pending_n;
      fifo_wr    <= fifo_wr_n;
      frame_done <= frame_done_n;
      prog_en    <= prog_en_n;
`ifdef INSN_LOADER_CHECKSUM_EN
      acc        <= acc_n;
      err_csum   <= err_n;
`endif
    end
  end

`ifndef INSN_LOADER_CHECKSUM_EN
  assign err_csum = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    len_n        = len;
    word_count_n = word_count;
    byte_idx_n   = byte_idx;
    word_buf_n   = word_buf;
    fifo_din_n   = fifo_din;
    pending_n    = pending;
    fifo_wr_n    = 1'b0;
    frame_done_n = 1'b0;
    prog_en_n    = frame_done ? 1'b0 : prog_en;
    emit         = 1'b0;
`ifdef INSN_LOADER_CHECKSUM_EN
    acc_n        = acc;
    err_n        = err_csum;
`endif
    unique case (state)
      IDLE: begin
        if (accept && s_data == SYNC_BYTE) begin
          word_count_n = '0;
          prog_en_n    = 1'b1;
          state_n      = LEN;
`ifdef INSN_LOADER_CHECKSUM_EN
          acc_n        = '0;
          err_n        = 1'b0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          len_n      = LEN_W'(s_data);
          byte_idx_n = '0;
          if (s_data == 8'd0) begin
`ifdef INSN_LOADER_CHECKSUM_EN
            state_n      = CSUM;
`else
            frame_done_n = 1'b1;
            state_n      = IDLE;
`endif
          end else begin
            state_n = DATA;
          end
        end
      end
      DATA: begin
        // A pending word is released on the first edge that sees the FIFO not full
        if (pending) begin
          if (!fifo_full) begin
            fifo_din_n = word_buf;
            emit       = 1'b1;
          end
        end else if (accept) begin
          word_buf_n = {s_data, word_buf[31:8]};
          byte_idx_n = byte_idx + 2'd1;
`ifdef INSN_LOADER_CHECKSUM_EN
          acc_n      = acc ^ s_data;
`endif
          if (byte_idx == 2'd3) begin
            if (fifo_full) begin
              pending_n = 1'b1;
            end else begin
              fifo_din_n = {s_data, word_buf[31:8]};
              emit       = 1'b1;
            end
          end
        end
      end
`ifdef INSN_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          err_n        = (s_data != acc);
          frame_done_n = 1'b1;
          state_n      = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (emit) begin
      fifo_wr_n    = 1'b1;
      pending_n    = 1'b0;
      word_count_n = wc_inc;
      if (wc_inc == len) begin
`ifdef INSN_LOADER_CHECKSUM_EN
        state_n      = CSUM;
`else
        frame_done_n = 1'b1;
        state_n      = IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_insn_loader.sv
// Directed scoreboard bench for insn_loader; follows INSN_LOADER_CHECKSUM_EN if defined.
module tb_insn_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [31:0] fifo_din;
  logic        prog_en;
  logic        frame_done;
  logic        err_csum;
  logic [7:0]  word_count;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned wr_count   = 0;
  int unsigned done_count = 0;
  logic        done_with_wr = 1'b0;
  logic [31:0] exp_q[$];
  int unsigned wr0, d0;

  insn_loader #(.SYNC_BYTE(8'hA5), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .prog_en(prog_en),
    .frame_done(frame_done), .err_csum(err_csum), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge, writes scored against the queue
  task automatic tick();
    @(posedge clk);
    #1;
    if (fifo_wr) begin
      wr_count++;
      if (exp_q.size() == 0) chk("unexpected_wr", 32'(fifo_wr), 32'd0);
      else chk("fifo_din", fifo_din, exp_q.pop_front());
    end
    if (frame_done) begin
      done_count++;
      done_with_wr = fifo_wr;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    s_data  = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; fifo_full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    chk("rst_prog_en", 32'(prog_en), 32'd0);
    chk("rst_err_csum", 32'(err_csum), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_fifo_din", fifo_din, 32'd0);
    tick(); tick();
    chk("idle_prog_en", 32'(prog_en), 32'd0);

    // Basic two-word frame
    wr0 = wr_count; d0 = done_count;
    exp_q.push_back(32'h0000_0110);
    exp_q.push_back(32'h0000_0020);
    send_byte(8'hA5);
    chk("f1_prog_en_on", 32'(prog_en), 32'd1);
    send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef INSN_LOADER_CHECKSUM_EN
    chk("f1_done_pending", done_count - d0, 32'd0);
    send_byte(8'h31);
    chk("f1_err_csum", 32'(err_csum), 32'd0);
`else
    chk("f1_done_with_wr", 32'(done_with_wr), 32'd1);
`endif
    chk("f1_prog_en_done", 32'(prog_en), 32'd1);
    chk("f1_done_count", done_count - d0, 32'd1);
    chk("f1_wr_count", wr_count - wr0, 32'd2);
    chk("f1_word_count", 32'(word_count), 32'd2);
    tick();
    chk("f1_prog_en_off", 32'(prog_en), 32'd0);

`ifdef INSN_LOADER_CHECKSUM_EN
    // Bad checksum is sticky until the next sync byte
    exp_q.push_back(32'h0000_0110);
    exp_q.push_back(32'h0000_0020);
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h30);
    chk("csum_err_set", 32'(err_csum), 32'd1);
    tick(); tick(); tick();
    chk("csum_err_held", 32'(err_csum), 32'd1);
    send_byte(8'hA5);
    chk("csum_err_clr", 32'(err_csum), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
`endif

    // Leading junk before sync
    wr0 = wr_count;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    chk("junk_prog_en", 32'(prog_en), 32'd0);
    chk("junk_no_wr", wr_count - wr0, 32'd0);
    exp_q.push_back(32'h0403_0201);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef INSN_LOADER_CHECKSUM_EN
    send_byte(8'h04);
    chk("junk_err_csum", 32'(err_csum), 32'd0);
`endif
    chk("junk_wr_count", wr_count - wr0, 32'd1);
    tick();

    // Zero-length frame
    wr0 = wr_count; d0 = done_count;
    send_byte(8'hA5); send_byte(8'h00);
`ifdef INSN_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("n0_done", done_count - d0, 32'd1);
    chk("n0_word_count", 32'(word_count), 32'd0);
    tick();
    chk("n0_no_wr", wr_count - wr0, 32'd0);

    // Back-pressure on the 4th byte of a word; next byte must wait, not drop
    wr0 = wr_count;
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    fifo_full = 1'b1;
    send_byte(8'h44);
    s_data = 8'h55; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("full_s_ready", 32'(s_ready), 32'd0);
    end
    chk("full_no_wr", wr_count - wr0, 32'd0);
    exp_q.push_back(32'h4433_2211);
    fifo_full = 1'b0;
    tick();
    chk("full_release_wr", wr_count - wr0, 32'd1);
    chk("full_word_count", 32'(word_count), 32'd1);
    exp_q.push_back(32'h8877_6655);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef INSN_LOADER_CHECKSUM_EN
    send_byte(8'h88);
    chk("full_err_csum", 32'(err_csum), 32'd0);
`endif
    chk("full_wr_count", wr_count - wr0, 32'd2);
    chk("full_word_count2", 32'(word_count), 32'd2);
    tick();

    // Reset mid-frame drops the partial word
    wr0 = wr_count;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_prog_en", 32'(prog_en), 32'd0);
    chk("abort_word_count", 32'(word_count), 32'd0);
    exp_q.push_back(32'h0000_0005);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`ifdef INSN_LOADER_CHECKSUM_EN
    send_byte(8'h05);
    chk("abort_err_csum", 32'(err_csum), 32'd0);
`endif
    tick(); tick();
    chk("abort_wr_count", wr_count - wr0, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
